bip_datapath_ext: RTL and testbench
===================================

// Module: bip_datapath_ext
// PURPOSE
//   Parametrised next-generation BIP datapath: accumulator, operand extension, A/B source muxes
//   and an extended ALU. Adds zero/sign extension, logic and shift ops, a Z/N/C/V status register
//   and a multi-cycle shift-add multiply with BUSY/DONE handshake.
//   Sits between the BIP control unit (drives SEL_A/SEL_B/WR_ACC/OP) and data memory.
// PARAMETERS
//   DATA_W  16  accumulator / data memory word width
//   OPND_W  11  instruction operand width; elaboration error if OPND_W > DATA_W
// PORTS
//   CLK          in   1       clock, rising edge
//   RESET_N      in   1       asynchronous reset, active low
//   OPERAND_IN   in   OPND_W  instruction operand field
//   DM_IN        in   DATA_W  data memory read data
//   SIGN_EXT     in   1       1: sign-extend OPERAND_IN, 0: zero-extend
//   SEL_A        in   2       ACC source: 00 DM_IN, 01 ext operand, 10 ALU result, 11 no write
//   SEL_B        in   1       ALU B source: 0 ext operand, 1 DM_IN
//   WR_ACC       in   1       write enable for ACC
//   OP           in   3       000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 SHL1 110 SHR1 111 MUL
//   ACC          out  DATA_W  accumulator (registered)
//   FLAGS        out  4       {Z,N,C,V} (registered)
//   BUSY         out  1       multiply in progress (registered)
//   DONE         out  1       one-cycle pulse: multiply result written (registered)
//   OPERAND_OUT  out  OPND_W  OPERAND_IN passed through combinationally
// BEHAVIOUR
//   Reset: ACC=0, FLAGS=0, BUSY=0, DONE=0, FSM=IDLE, mul counter/partials=0. Asynchronous, so it aborts any multiply.
//   Extension: ext = SIGN_EXT ? {replicated OPERAND_IN[OPND_W-1], OPERAND_IN} : {zeros, OPERAND_IN}.
//   IDLE, WR_ACC=1: SEL_A=00 -> ACC<=DM_IN; 01 -> ACC<=ext; 11 -> hold. Flags unchanged for these.
//   IDLE, WR_ACC=1, SEL_A=10, OP!=MUL -> ACC<=alu(ACC,B) and FLAGS<=alu flags at the same edge.
//     Latency is 1 clock.
//   Flags: Z = result==0. N = result[DATA_W-1].
//     ADD: C = carry out, V = signed overflow.
//     SUB: computed as A+~B+1. C = carry out (1 = no borrow). V = signed overflow.
//     AND/OR/XOR: C=0, V=0.
//     SHL1: C = A[DATA_W-1], V=0. SHR1 is logical: C = A[0], V=0.
//   MUL start: IDLE and WR_ACC=1, SEL_A=10, OP=111.
//     Latch multiplicand=ACC, multiplier=B, product=0. Go to MUL, BUSY<=1.
//   MUL state: one shift-add step per cycle, for exactly DATA_W cycles; BUSY stays high throughout.
//     On the last step's edge: ACC <= product[DATA_W-1:0], Z/N from that value.
//     C = |product[2*DATA_W-1:DATA_W], V = 0. BUSY<=0, DONE<=1 for one cycle, return to IDLE.
//   While BUSY: WR_ACC/SEL/OP ignored, ACC and FLAGS hold. Control unit must stall.
//   A new start in the cycle DONE is high is legal (FSM is already IDLE).
//   All arithmetic is modulo 2^DATA_W; no saturation.
//   FSM states: IDLE, MUL. Counter width is clog2(DATA_W+1).
// STRUCTURE
//   bip_pkg: OP_* opcode localparams, SELA_* codes, FLAG_Z/N/C/V bit indices, FSM state encoding.
//   Sub-module bip_alu #(DATA_W): combinational A,B,OP -> result, C, V (MUL not handled).
//   Top holds the ACC/FLAGS registers, muxes, extension and the multiply FSM/datapath.
// TESTING (DATA_W=16, OPND_W=11)
//   1. RESET_N low mid-run -> ACC=0, FLAGS=0, BUSY=0, DONE=0 immediately (before next CLK edge).
//   2. OPERAND_IN=11'h7FF, SEL_A=01, WR_ACC=1: SIGN_EXT=1 -> ACC=16'hFFFF; SIGN_EXT=0 -> 16'h07FF.
//   3. ACC=16'h7FFF, DM_IN=1, SEL_B=1, ADD -> ACC=16'h8000, {Z,N,C,V}=0101.
//      ACC=16'hFFFF + 1 -> ACC=0, {Z,N,C,V}=1010.
//   4. ACC=5, ext operand=5, SUB -> ACC=0, {Z,N,C,V}=1010.
//      ACC=3, operand 5, SUB -> ACC=16'hFFFE, {Z,N,C,V}=0100.
//   5. ACC=300, DM_IN=300, MUL -> BUSY high 16 cycles, then ACC=16'h5F90, C=1, DONE pulses once.
//      WR_ACC with SEL_A=00 during BUSY leaves ACC unchanged.
//   6. Start MUL, drop RESET_N after 8 busy cycles -> ACC=0, BUSY=0, no DONE.
//      A fresh ADD after release works normally.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared opcodes, source-select codes, flag indices and FSM encoding
// for the extended BIP datapath.
package bip_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] SELA_DM   = 2'b00;
  localparam logic [1:0] SELA_EXT  = 2'b01;
  localparam logic [1:0] SELA_ALU  = 2'b10;
  localparam logic [1:0] SELA_HOLD = 2'b11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic [3:0] mk_flags(
    input logic z,
    input logic n,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/bip_alu.sv
// Combinational ALU: add/sub/logic/shift with carry and overflow.
// Multiply is sequenced by the top and yields zero here.
module bip_alu
  import bip_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] res,
  output logic              c,
  output logic              v
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (op)
      OP_ADD: begin
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a[DATA_W-1] == b[DATA_W-1]) &&
              (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        res = dif[DATA_W-1:0];
        c   = dif[DATA_W];
        v   = (a[DATA_W-1] != b[DATA_W-1]) &&
              (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res = {a[DATA_W-2:0], 1'b0};
        c   = a[DATA_W-1];
      end
      OP_SHR: begin
        res = {1'b0, a[DATA_W-1:1]};
        c   = a[0];
      end
      OP_MUL: res = '0;
    endcase
  end

endmodule

// File: rtl/bip_datapath_ext.sv
// BIP datapath: accumulator, operand extension, source muxes, ALU
// and a DATA_W-step shift-add multiplier with BUSY/DONE handshake.
module bip_datapath_ext
  import bip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPND_W = 11
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [OPND_W-1:0] OPERAND_IN,
  input  logic [DATA_W-1:0] DM_IN,
  input  logic              SIGN_EXT,
  input  logic [1:0]        SEL_A,
  input  logic              SEL_B,
  input  logic              WR_ACC,
  input  logic [2:0]        OP,
  output logic [DATA_W-1:0] ACC,
  output logic [3:0]        FLAGS,
  output logic              BUSY,
  output logic              DONE,
  output logic [OPND_W-1:0] OPERAND_OUT
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  generate
    if (OPND_W > DATA_W) begin : g_bad_w
      $error("OPND_W must not exceed DATA_W");
    end
  endgenerate

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_nx;
  logic [DATA_W-1:0]   ext;
  logic [DATA_W-1:0]   b_src;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;

  assign OPERAND_OUT = OPERAND_IN;

  assign ext = SIGN_EXT ? DATA_W'($signed(OPERAND_IN))
                        : DATA_W'(OPERAND_IN);
  assign b_src = SEL_B ? DM_IN : ext;

  assign prod_nx = prod + (mplier[0] ? mcand : '0);

  bip_alu #(.DATA_W(DATA_W)) u_alu (
    .a   (ACC),
    .b   (b_src),
    .op  (OP),
    .res (alu_res),
    .c   (alu_c),
    .v   (alu_v)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ACC    <= '0;
      FLAGS  <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      state  <= ST_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (WR_ACC) begin
            unique case (SEL_A)
              SELA_DM:   ACC <= DM_IN;
              SELA_EXT:  ACC <= ext;
              SELA_ALU: begin
                if (OP == OP_MUL) begin
                  state  <= ST_MUL;
                  BUSY   <= 1'b1;
                  cnt    <= '0;
                  mcand  <= {{DATA_W{1'b0}}, ACC};
                  mplier <= b_src;
                  prod   <= '0;
                end else begin
                  ACC   <= alu_res;
                  FLAGS <= mk_flags(alu_res == '0,
                                    alu_res[DATA_W-1],
                                    alu_c, alu_v);
                end
              end
              SELA_HOLD: ;
            endcase
          end
        end
        ST_MUL: begin
          prod   <= prod_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Final step commits the low word; high word feeds C.
          if (cnt == LAST) begin
            ACC   <= prod_nx[DATA_W-1:0];
            FLAGS <= mk_flags(prod_nx[DATA_W-1:0] == '0,
                              prod_nx[DATA_W-1],
                              |prod_nx[2*DATA_W-1:DATA_W],
                              1'b0);
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_datapath_ext.sv
// Directed self-checking bench for bip_datapath_ext
// (DATA_W=16, OPND_W=11) with hand-computed expectations.
module tb_bip_datapath_ext;

  logic        CLK;
  logic        RESET_N;
  logic [10:0] OPERAND_IN;
  logic [15:0] DM_IN;
  logic        SIGN_EXT;
  logic [1:0]  SEL_A;
  logic        SEL_B;
  logic        WR_ACC;
  logic [2:0]  OP;
  logic [15:0] ACC;
  logic [3:0]  FLAGS;
  logic        BUSY;
  logic        DONE;
  logic [10:0] OPERAND_OUT;

  int checks   = 0;
  int failures = 0;
  int busy_cnt;
  int done_cnt;
  bit hold_ok;

  bip_datapath_ext #(.DATA_W(16), .OPND_W(11)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .OPERAND_IN  (OPERAND_IN),
    .DM_IN       (DM_IN),
    .SIGN_EXT    (SIGN_EXT),
    .SEL_A       (SEL_A),
    .SEL_B       (SEL_B),
    .WR_ACC      (WR_ACC),
    .OP          (OP),
    .ACC         (ACC),
    .FLAGS       (FLAGS),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .OPERAND_OUT (OPERAND_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_dm(input logic [15:0] d);
    WR_ACC = 1'b1;
    SEL_A  = 2'b00;
    DM_IN  = d;
    step();
  endtask

  task automatic alu_op(input logic [2:0] op, input logic sb);
    WR_ACC = 1'b1;
    SEL_A  = 2'b10;
    SEL_B  = sb;
    OP     = op;
    step();
  endtask

  initial begin
    RESET_N    = 1'b0;
    OPERAND_IN = '0;
    DM_IN      = '0;
    SIGN_EXT   = 1'b0;
    SEL_A      = 2'b11;
    SEL_B      = 1'b0;
    WR_ACC     = 1'b0;
    OP         = 3'd0;
    step();
    step();
    chk("rst_acc",   32'(ACC),   32'h0);
    chk("rst_flags", 32'(FLAGS), 32'h0);
    chk("rst_busy",  32'(BUSY),  32'h0);
    chk("rst_done",  32'(DONE),  32'h0);
    #2 RESET_N = 1'b1;

    // Operand extension and passthrough
    OPERAND_IN = 11'h7FF;
    #1 chk("opnd_out", 32'(OPERAND_OUT), 32'h7FF);
    SIGN_EXT = 1'b1; SEL_A = 2'b01; WR_ACC = 1'b1;
    step();
    chk("sext", 32'(ACC), 32'hFFFF);
    SIGN_EXT = 1'b0;
    step();
    chk("zext", 32'(ACC), 32'h07FF);
    chk("ext_flags", 32'(FLAGS), 32'h0);
    SEL_A = 2'b11;
    step();
    chk("hold", 32'(ACC), 32'h07FF);

    // ADD overflow and carry
    load_dm(16'h7FFF);
    DM_IN = 16'h0001;
    alu_op(3'd0, 1'b1);
    chk("add_ov_acc", 32'(ACC), 32'h8000);
    chk("add_ov_flg", 32'(FLAGS), 32'b0101);
    load_dm(16'hFFFF);
    DM_IN = 16'h0001;
    alu_op(3'd0, 1'b1);
    chk("add_c_acc", 32'(ACC), 32'h0000);
    chk("add_c_flg", 32'(FLAGS), 32'b1010);

    // SUB via extended operand
    SIGN_EXT = 1'b0; OPERAND_IN = 11'd5; SEL_A = 2'b01;
    step();
    alu_op(3'd1, 1'b0);
    chk("sub_eq_acc", 32'(ACC), 32'h0000);
    chk("sub_eq_flg", 32'(FLAGS), 32'b1010);
    OPERAND_IN = 11'd3; SEL_A = 2'b01;
    step();
    OPERAND_IN = 11'd5;
    alu_op(3'd1, 1'b0);
    chk("sub_neg_acc", 32'(ACC), 32'hFFFE);
    chk("sub_neg_flg", 32'(FLAGS), 32'b0100);

    // Shifts and logic
    alu_op(3'd5, 1'b0);
    chk("shl_acc", 32'(ACC), 32'hFFFC);
    chk("shl_flg", 32'(FLAGS), 32'b0110);
    alu_op(3'd6, 1'b0);
    chk("shr_acc", 32'(ACC), 32'h7FFE);
    chk("shr_flg", 32'(FLAGS), 32'b0000);
    DM_IN = 16'h0F0F;
    alu_op(3'd2, 1'b1);
    chk("and_acc", 32'(ACC), 32'h0F0E);
    DM_IN = 16'h3000;
    alu_op(3'd3, 1'b1);
    chk("or_acc", 32'(ACC), 32'h3F0E);
    DM_IN = 16'h3F0E;
    alu_op(3'd4, 1'b1);
    chk("xor_acc", 32'(ACC), 32'h0000);
    chk("xor_flg", 32'(FLAGS), 32'b1000);

    // Multiply 300*300 = 0x15F90
    load_dm(16'd300);
    alu_op(3'd7, 1'b1);
    chk("mul_busy0", 32'(BUSY), 32'h1);
    busy_cnt = 1;
    done_cnt = 0;
    hold_ok  = 1'b1;
    SEL_A = 2'b00; DM_IN = 16'h1234; WR_ACC = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (DONE) done_cnt++;
      if (!BUSY) break;
      busy_cnt++;
      if (ACC !== 16'd300) hold_ok = 1'b0;
    end
    WR_ACC = 1'b0;
    chk("mul_busy_len", 32'(busy_cnt), 32'd16);
    chk("mul_hold", 32'(hold_ok), 32'h1);
    chk("mul_done", 32'(DONE), 32'h1);
    chk("mul_acc", 32'(ACC), 32'h5F90);
    chk("mul_flg", 32'(FLAGS), 32'b0010);
    step();
    if (DONE) done_cnt++;
    chk("mul_done_pulse", 32'(done_cnt), 32'd1);
    chk("mul_acc_keep", 32'(ACC), 32'h5F90);

    // Asynchronous reset aborts a multiply
    load_dm(16'd300);
    alu_op(3'd7, 1'b1);
    WR_ACC = 1'b0;
    repeat (8) step();
    chk("abort_busy_pre", 32'(BUSY), 32'h1);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_acc",   32'(ACC),   32'h0);
    chk("abort_flags", 32'(FLAGS), 32'h0);
    chk("abort_busy",  32'(BUSY),  32'h0);
    chk("abort_done",  32'(DONE),  32'h0);
    #1 RESET_N = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (DONE) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle", 32'(BUSY), 32'h0);

    load_dm(16'd2);
    DM_IN = 16'd3;
    alu_op(3'd0, 1'b1);
    chk("post_add_acc", 32'(ACC), 32'd5);
    chk("post_add_flg", 32'(FLAGS), 32'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
